// File: rtl/inst_encoder_writer_pkg.sv
// Shared RV32I encoding constants, operation enums and writer types.
// Imported by the encoder, the writer top and round-trip benches.
package inst_encoder_writer_pkg;

  localparam int OPENUM_LEN = 6;
  localparam int REG_LEN    = 5;
  localparam int DATA_LEN   = 32;
  localparam int INST_LEN   = 32;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;
  localparam logic [2:0] FUNC3_B    = 3'b000;
  localparam logic [2:0] FUNC3_H    = 3'b001;
  localparam logic [2:0] FUNC3_W    = 3'b010;
  localparam logic [2:0] FUNC3_BU   = 3'b100;
  localparam logic [2:0] FUNC3_HU   = 3'b101;
  localparam logic [2:0] FUNC3_ADD  = 3'b000;
  localparam logic [2:0] FUNC3_SLL  = 3'b001;
  localparam logic [2:0] FUNC3_SLT  = 3'b010;
  localparam logic [2:0] FUNC3_SLTU = 3'b011;
  localparam logic [2:0] FUNC3_XOR  = 3'b100;
  localparam logic [2:0] FUNC3_SR   = 3'b101;
  localparam logic [2:0] FUNC3_OR   = 3'b110;
  localparam logic [2:0] FUNC3_AND  = 3'b111;

  localparam logic [6:0] FUNC7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNC7_SPEC = 7'b0100000;

  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP   = 6'd0;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LUI   = 6'd1;
  localparam logic [OPENUM_LEN-1:0] OPENUM_AUIPC = 6'd2;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JAL   = 6'd3;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JALR  = 6'd4;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BEQ   = 6'd5;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BNE   = 6'd6;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BLT   = 6'd7;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BGE   = 6'd8;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BLTU  = 6'd9;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BGEU  = 6'd10;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LB    = 6'd11;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LH    = 6'd12;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LW    = 6'd13;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LBU   = 6'd14;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LHU   = 6'd15;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SB    = 6'd16;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SH    = 6'd17;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SW    = 6'd18;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADDI  = 6'd19;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTI  = 6'd20;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTIU = 6'd21;
  localparam logic [OPENUM_LEN-1:0] OPENUM_XORI  = 6'd22;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ORI   = 6'd23;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ANDI  = 6'd24;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLLI  = 6'd25;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRLI  = 6'd26;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADD   = 6'd27;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SUB   = 6'd28;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLL   = 6'd29;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLT   = 6'd30;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTU  = 6'd31;
  localparam logic [OPENUM_LEN-1:0] OPENUM_XOR   = 6'd32;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRL   = 6'd33;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRA   = 6'd34;
  localparam logic [OPENUM_LEN-1:0] OPENUM_OR    = 6'd35;
  localparam logic [OPENUM_LEN-1:0] OPENUM_AND   = 6'd36;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_B0, ST_B1, ST_B2, ST_B3
  } wr_state_e;

endpackage

// File: rtl/inst_encoder_writer_encode_comb.sv
// Pure combinational RV32I encoder: op enum + fields -> word, legal.
// NOP ignores its fields and always yields addi x0,x0,0.
module inst_encode_comb
  import inst_encoder_writer_pkg::*;
(
  input  logic [OPENUM_LEN-1:0] op,
  input  logic [REG_LEN-1:0]    rd,
  input  logic [REG_LEN-1:0]    rs1,
  input  logic [REG_LEN-1:0]    rs2,
  input  logic [DATA_LEN-1:0]   imm,
  output logic [INST_LEN-1:0]   word,
  output logic                  legal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  fmt_e       fmt;
  logic       nop;
  logic       unused_imm;

  assign unused_imm = ^imm[31:21];

  // Map the op enum to opcode, funct fields and format
  always_comb begin
    opc   = OPCODE_OP_IMM;
    f3    = FUNC3_ADD;
    f7    = FUNC7_ZERO;
    fmt   = FMT_I;
    legal = 1'b1;
    nop   = 1'b0;
    case (op)
      OPENUM_NOP:   nop = 1'b1;
      OPENUM_LUI:   begin opc = OPCODE_LUI; fmt = FMT_U; end
      OPENUM_AUIPC: begin opc = OPCODE_AUIPC; fmt = FMT_U; end
      OPENUM_JAL:   begin opc = OPCODE_JAL; fmt = FMT_J; end
      OPENUM_JALR:  opc = OPCODE_JALR;
      OPENUM_BEQ:   begin opc = OPCODE_BRANCH; fmt = FMT_B; f3 = FUNC3_BEQ; end
      OPENUM_BNE:   begin opc = OPCODE_BRANCH; fmt = FMT_B; f3 = FUNC3_BNE; end
      OPENUM_BLT:   begin opc = OPCODE_BRANCH; fmt = FMT_B; f3 = FUNC3_BLT; end
      OPENUM_BGE:   begin opc = OPCODE_BRANCH; fmt = FMT_B; f3 = FUNC3_BGE; end
      OPENUM_BLTU:  begin opc = OPCODE_BRANCH; fmt = FMT_B; f3 = FUNC3_BLTU; end
      OPENUM_BGEU:  begin opc = OPCODE_BRANCH; fmt = FMT_B; f3 = FUNC3_BGEU; end
      OPENUM_LB:    begin opc = OPCODE_LOAD; f3 = FUNC3_B; end
      OPENUM_LH:    begin opc = OPCODE_LOAD; f3 = FUNC3_H; end
      OPENUM_LW:    begin opc = OPCODE_LOAD; f3 = FUNC3_W; end
      OPENUM_LBU:   begin opc = OPCODE_LOAD; f3 = FUNC3_BU; end
      OPENUM_LHU:   begin opc = OPCODE_LOAD; f3 = FUNC3_HU; end
      OPENUM_SB:    begin opc = OPCODE_STORE; fmt = FMT_S; f3 = FUNC3_B; end
      OPENUM_SH:    begin opc = OPCODE_STORE; fmt = FMT_S; f3 = FUNC3_H; end
      OPENUM_SW:    begin opc = OPCODE_STORE; fmt = FMT_S; f3 = FUNC3_W; end
      OPENUM_ADDI:  f3 = FUNC3_ADD;
      OPENUM_SLTI:  f3 = FUNC3_SLT;
      OPENUM_SLTIU: f3 = FUNC3_SLTU;
      OPENUM_XORI:  f3 = FUNC3_XOR;
      OPENUM_ORI:   f3 = FUNC3_OR;
      OPENUM_ANDI:  f3 = FUNC3_AND;
      OPENUM_SLLI:  begin fmt = FMT_SH; f3 = FUNC3_SLL; end
      OPENUM_SRLI:  begin fmt = FMT_SH; f3 = FUNC3_SR; end
      OPENUM_ADD:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_ADD; end
      OPENUM_SUB:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_ADD; f7 = FUNC7_SPEC; end
      OPENUM_SLL:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_SLL; end
      OPENUM_SLT:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_SLT; end
      OPENUM_SLTU:  begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_SLTU; end
      OPENUM_XOR:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_XOR; end
      OPENUM_SRL:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_SR; end
      OPENUM_SRA:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_SR; f7 = FUNC7_SPEC; end
      OPENUM_OR:    begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_OR; end
      OPENUM_AND:   begin opc = OPCODE_OP; fmt = FMT_R; f3 = FUNC3_AND; end
      default:      legal = 1'b0;
    endcase
  end

  // Pack the fields according to the instruction format
  always_comb begin
    word = '0;
    unique case (fmt)
      FMT_R:   word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:   word = {imm[11:0], rs1, f3, rd, opc};
      FMT_SH:  word = {f7, imm[4:0], rs1, f3, rd, opc};
      FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3,
                       imm[4:1], imm[11], opc};
      FMT_U:   word = {imm[19:0], rd, opc};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12],
                       rd, opc};
      default: word = '0;
    endcase
    if (nop) word = {25'd0, OPCODE_OP_IMM};
  end

endmodule

// File: rtl/inst_encoder_writer.sv
// Encodes decoded fields into RV32I words, buffers them in a FIFO and
// streams each word little-endian, one byte per cycle, to a RAM port.
module inst_encoder_writer
  import inst_encoder_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPENUM_LEN-1:0] in_op_enum,
  input  logic [REG_LEN-1:0]    in_rd,
  input  logic [REG_LEN-1:0]    in_rs1,
  input  logic [REG_LEN-1:0]    in_rs2,
  input  logic [DATA_LEN-1:0]   in_imm,
  input  logic                  load_addr,
  input  logic [31:0]           load_addr_val,
  output logic                  mem_wr,
  output logic [31:0]           mem_a,
  output logic [7:0]            mem_dout,
  output logic                  busy,
  output logic                  illegal,
  output logic [31:0]           words_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INST_LEN-1:0] fifo [DEPTH];
  logic [AW-1:0]       wp;
  logic [AW-1:0]       rp;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic                ready_q;
  logic                wr_q;
  logic [INST_LEN-1:0] enc_word;
  logic                enc_legal;
  logic [INST_LEN-1:0] head;
  logic [23:0]         word_q;
  logic [31:0]         ptr;
  wr_state_e           state;
  logic                hs;
  logic                push;
  logic                pop;
  logic                ld_ok;
  logic                empty;

  inst_encode_comb u_enc (
    .op    (in_op_enum),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign empty     = (count == '0);
  assign in_ready  = rdy && ready_q;
  assign hs        = in_valid && in_ready;
  assign push      = hs && enc_legal;
  assign pop       = rdy && !empty &&
                     (state == ST_IDLE || state == ST_B3);
  assign ld_ok     = rdy && load_addr && empty && state == ST_IDLE;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head      = fifo[rp];
  assign busy      = !empty || state != ST_IDLE;
  assign mem_wr    = wr_q && rdy;

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= enc_word;
  end

  // FIFO pointers, occupancy and the registered not-full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else if (rdy) begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count   <= count_nxt;
      ready_q <= (count_nxt != CW'(DEPTH));
    end
  end

  // Byte writer FSM with registered RAM port and drop pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      word_q     <= '0;
      wr_q       <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      words_done <= '0;
      illegal    <= 1'b0;
    end else begin
      illegal <= hs && !enc_legal;
      if (rdy) begin
        unique case (state)
          ST_IDLE: begin
            if (ld_ok) ptr <= load_addr_val;
            if (pop) begin
              word_q   <= head[31:8];
              mem_a    <= ptr;
              mem_dout <= head[7:0];
              wr_q     <= 1'b1;
              state    <= ST_B0;
            end
          end
          ST_B0: begin
            mem_a    <= ptr + 32'd1;
            mem_dout <= word_q[7:0];
            state    <= ST_B1;
          end
          ST_B1: begin
            mem_a    <= ptr + 32'd2;
            mem_dout <= word_q[15:8];
            state    <= ST_B2;
          end
          ST_B2: begin
            mem_a    <= ptr + 32'd3;
            mem_dout <= word_q[23:16];
            state    <= ST_B3;
          end
          ST_B3: begin
            ptr        <= ptr + 32'd4;
            words_done <= words_done + 32'd1;
            if (pop) begin
              word_q   <= head[31:8];
              mem_a    <= ptr + 32'd4;
              mem_dout <= head[7:0];
              state    <= ST_B0;
            end else begin
              wr_q  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Directed bench for inst_encoder_writer: encodings, byte stream,
// backpressure, rdy stall, illegal drop, load gating and reset.
module tb_inst_encoder_writer;
  import inst_encoder_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op_enum = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        load_addr = 1'b0;
  logic [31:0] load_addr_val = '0;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        busy;
  logic        illegal;
  logic [31:0] words_done;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0] wa [$];
  logic [7:0]  wd [$];
  int          wc [$];

  inst_encoder_writer #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op_enum    (in_op_enum),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .load_addr     (load_addr),
    .load_addr_val (load_addr_val),
    .mem_wr        (mem_wr),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .busy          (busy),
    .illegal       (illegal),
    .words_done    (words_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_wr) begin
      wa.push_back(mem_a);
      wd.push_back(mem_dout);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    in_op_enum = op;
    in_rd = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_word(input string tag, input int idx,
                          input logic [31:0] addr,
                          input logic [31:0] word, input bit contig);
    logic [31:0] obs;
    if (wa.size() < idx + 4) begin
      chk({tag, "_count"}, 32'(wa.size()), 32'(idx + 4));
      return;
    end
    obs = {wd[idx+3], wd[idx+2], wd[idx+1], wd[idx]};
    chk({tag, "_word"}, obs, word);
    chk({tag, "_a0"}, wa[idx], addr);
    chk({tag, "_a3"}, wa[idx+3], addr + 32'd3);
    if (contig) chk({tag, "_cyc"}, 32'(wc[idx+3] - wc[idx]), 32'd3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  initial begin
    int acc;
    int acc_at_low;
    bit saw_low;
    logic [31:0] wd0;
    logic [31:0] a0;
    logic [31:0] w;
    int n;

    // reset state
    #1;
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_words", words_done, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b1;
    chk("pre_edge_ready", 32'(in_ready), 32'd0);
    step();
    chk("post_edge_ready", 32'(in_ready), 32'd1);

    // single U-type word at a loaded address
    load_addr = 1'b1;
    load_addr_val = 32'h100;
    send(OPENUM_LUI, 5'd2, 5'd0, 5'd0, 32'h12345);
    load_addr = 1'b0;
    chk("lui_busy", 32'(busy), 32'd1);
    wait_idle("lui");
    chk_word("lui", 0, 32'h100, 32'h12345137, 1'b1);
    if (wd.size() >= 2) begin
      chk("lui_b0", 32'(wd[0]), 32'h37);
      chk("lui_b1", 32'(wd[1]), 32'h51);
    end
    chk("lui_words", words_done, 32'd1);

    // back-to-back addi / sub from reset
    do_reset();
    send(OPENUM_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(OPENUM_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    wait_idle("rr");
    chk_word("addi", 0, 32'd0, 32'h00500093, 1'b1);
    chk_word("sub", 4, 32'd4, 32'h402081B3, 1'b1);
    if (wc.size() >= 5) chk("rr_gap", 32'(wc[4] - wc[3]), 32'd1);
    chk("rr_words", words_done, 32'd2);

    // branch, store and jump immediates
    send(OPENUM_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
    send(OPENUM_SW, 5'd0, 5'd1, 5'd2, 32'd4);
    send(OPENUM_JAL, 5'd1, 5'd0, 5'd0, 32'd16);
    wait_idle("bsj");
    chk_word("beq", 8, 32'd8, 32'h00208463, 1'b1);
    chk_word("sw", 12, 32'd12, 32'h0020A223, 1'b1);
    chk_word("jal", 16, 32'd16, 32'h010000EF, 1'b1);
    chk("bsj_words", words_done, 32'd5);

    // backpressure: six back-to-back pushes into a 4-deep FIFO
    // (one word drains into the writer, so ready drops after 5)
    acc = 0;
    acc_at_low = -1;
    saw_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_op_enum = OPENUM_ADDI;
      in_rd = 5'(i + 1);
      in_rs1 = 5'd0;
      in_rs2 = 5'd0;
      in_imm = 32'(i + 1);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
        if (!saw_low) begin
          acc_at_low = acc;
          saw_low = 1'b1;
        end
        step();
        n++;
      end
      step();
      acc++;
    end
    in_valid = 1'b0;
    chk("bp_acc_at_low", 32'(acc_at_low), 32'd5);
    rdy = 1'b0;
    #1;
    chk("stall_ready", 32'(in_ready), 32'd0);
    chk("stall_wr", 32'(mem_wr), 32'd0);
    wd0 = words_done;
    a0 = mem_a;
    repeat (5) step();
    chk("stall_words", words_done, wd0);
    chk("stall_addr", mem_a, a0);
    chk("stall_wr2", 32'(mem_wr), 32'd0);
    rdy = 1'b1;
    wait_idle("bp");
    for (int i = 0; i < 6; i++) begin
      w = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
      chk_word($sformatf("bp%0d", i), 20 + 4 * i,
               32'(20 + 4 * i), w, 1'b0);
    end
    chk("bp_words", words_done, 32'd11);

    // undefined enum is dropped with a one-cycle pulse
    send(6'd50, 5'd1, 5'd1, 5'd1, 32'd1);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    step();
    chk("ill_clear", 32'(illegal), 32'd0);
    repeat (4) step();
    chk("ill_nowrite", 32'(wa.size()), 32'd44);

    // NOP ignores its fields
    send(OPENUM_NOP, 5'd7, 5'd9, 5'd3, 32'hFFF);
    chk("nop_ill", 32'(illegal), 32'd0);
    wait_idle("nop");
    chk_word("nop", 44, 32'd44, 32'h00000013, 1'b1);

    // load_addr while busy is ignored
    send(OPENUM_ADDI, 5'd7, 5'd0, 5'd0, 32'd7);
    chk("ld_busy", 32'(busy), 32'd1);
    load_addr = 1'b1;
    load_addr_val = 32'h800;
    step();
    load_addr = 1'b0;
    send(OPENUM_ORI, 5'd4, 5'd5, 5'd0, 32'h0F0);
    wait_idle("ld");
    chk_word("ld_a", 48, 32'd48, 32'h00700393, 1'b1);
    chk_word("ld_b", 52, 32'd52, 32'h0F02E213, 1'b1);
    chk("ld_words", words_done, 32'd14);

    // reset in the middle of a word
    send(OPENUM_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    n = 0;
    while (!(mem_wr && mem_a[1:0] == 2'd2) && n < 50) begin
      step();
      n++;
    end
    chk("mid_reach_b2", 32'(mem_wr && mem_a[1:0] == 2'd2), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_wr", 32'(mem_wr), 32'd0);
    chk("mid_addr", mem_a, 32'd0);
    chk("mid_words", words_done, 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    step();
    wa.delete();
    wd.delete();
    wc.delete();
    send(OPENUM_ANDI, 5'd6, 5'd1, 5'd0, 32'h00F);
    wait_idle("mid");
    chk_word("mid_next", 0, 32'd0, 32'h00F0F313, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
